axi_r_chan_burst_arbiter: RTL and testbench
===========================================

// Module: axi_r_chan_burst_arbiter
// PURPOSE
//  Round-robin arbiter that shares one downstream R-channel flushable spill register among
//  NumInp R-beat sources in axi_to_mem (e.g. per-bank read response paths).
//  Grant locks to one requester from its first beat until its beat with last=1 completes the
//  handshake, so bursts are never interleaved on the shared channel.
//  Output is combinational (mux plus handshake); the downstream spill register supplies the
//  register stage. Its flush_i is driven from this block's flush_i.
// PARAMETERS
//  NumInp     4   number of requesters, >=2
//  IdWidth    4   R id width
//  DataWidth  64  R data width
//  UserWidth  1   R user width
//  BeatW      derived = IdWidth+DataWidth+3+UserWidth; beat = {id,data,resp[1:0],last,user}
//  IdxW       derived = (NumInp>1) ? $clog2(NumInp) : 1
// PORTS
//  clk_i      in   1            clock, rising edge
//  rst_ni     in   1            asynchronous active-low reset
//  flush_i    in   1            synchronous flush: abort lock, reset priority
//  valid_i    in   NumInp       per-requester beat valid
//  ready_o    out  NumInp       per-requester beat ready
//  data_i     in   NumInp*BeatW requester k beat at [k*BeatW +: BeatW]
//  valid_o    out  1            beat valid to spill register
//  ready_i    in   1            spill register ready
//  data_o     out  BeatW        granted beat
//  idx_o      out  IdxW         index of granted requester (valid when valid_o=1)
//  locked_o   out  1            burst lock held (state LOCKED)
// BEHAVIOUR
//  - Reset: state=IDLE, rr_q=0, lock_idx_q=0.
//    Outputs: valid_o=0, ready_o=0, data_o=0, idx_o=0, locked_o=0.
//  - last bit of a beat = bit index UserWidth.
//  - Selection sel:
//      IDLE:   first k with valid_i[k]=1, searching k=rr_q,rr_q+1,..., wrapping modulo NumInp.
//      LOCKED: sel = lock_idx_q.
//  - Outputs:
//      valid_o  = valid_i[sel] & ~flush_i
//      data_o   = data_i[sel]; 0 when no valid input in IDLE
//      idx_o    = sel
//      ready_o[sel] = ready_i & ~flush_i; all other ready_o bits = 0
//      Zero latency from input to output.
//  - Handshake hs = valid_o & ready_i.
//  - State machine (two states):
//      IDLE -> LOCKED: valid_o & ~(hs & last). Covers a stalled first beat (AXI stability) and a
//        completed non-last beat. lock_idx_q <= sel.
//      IDLE -> IDLE: hs & last (single-beat burst). rr_q <= (sel+1) mod NumInp.
//      LOCKED -> IDLE: hs & last. rr_q <= (lock_idx_q+1) mod NumInp.
//      LOCKED -> LOCKED: otherwise, including valid_i[lock_idx_q]=0 gaps mid-burst.
//        Other requesters stay blocked.
//  - The rr_q wrap from NumInp-1 to 0 is explicit; it must be correct for non-power-of-2 NumInp.
//  - flush_i=1 (highest priority, synchronous):
//      next state=IDLE, rr_q<=0; valid_o=0 and ready_o=0 in the flush cycle.
//      No beat is transferred in that cycle.
//  - Async reset mid-burst: immediate return to reset values; no partial-burst memory.
//  - A requester that deasserts valid_i before its handshake violates AXI; behaviour is undefined.
// TESTING
//  - Reset: hold rst_ni=0 with all valid_i=1 -> valid_o=0, ready_o=0, locked_o=0.
//    Release -> idx_o=0 in the same cycle.
//  - RR fairness: all 4 valid, 1-beat bursts, ready_i=1 -> grant order 0,1,2,3,0 on successive
//    cycles, one hs per cycle.
//  - Burst lock: req1 sends 4-beat burst (last on beat 4), req0 and req2 valid throughout ->
//    idx_o=1 for 4 hs, locked_o=1 for 3 cycles, next grant=2.
//  - Stall stability: req3 valid, ready_i=0 for 5 cycles, then req0 raises valid ->
//    data_o and idx_o=3 stable, locked_o=1, ready_o=0.
//  - Gap and flush: req2 mid-burst deasserts valid for 2 cycles -> valid_o=0, req1 not granted.
//    flush_i pulse -> locked_o=0; next cycle with req1,req2 valid gives idx_o=1 (rr_q=0 search).
//  - NumInp=3 wrap: grant 2 with last -> rr_q=0, next grant 0 when all valid.

Source files
------------

// File: rtl/axi_r_chan_burst_arbiter.sv
// Round-robin R-channel arbiter that locks the grant for a whole burst, so bursts from
// different sources never interleave in front of the shared downstream spill register.
module axi_r_chan_burst_arbiter #(
   parameter int unsigned NumInp    = 4,
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned UserWidth = 1,
   localparam int unsigned BeatW    = IdWidth + DataWidth + 3 + UserWidth,
   localparam int unsigned IdxW     = (NumInp > 1) ? $clog2(NumInp) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_i,
   input  logic [NumInp-1:0]       valid_i,
   output logic [NumInp-1:0]       ready_o,
   input  logic [NumInp*BeatW-1:0] data_i,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic [BeatW-1:0]        data_o,
   output logic [IdxW-1:0]         idx_o,
   output logic                    locked_o
);

   typedef enum logic {
      StIdle,
      StLocked
   } state_e;

   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumInp - 1);

   state_e           state_q, state_d;
   logic [IdxW-1:0]  rr_q, rr_d;
   logic [IdxW-1:0]  lock_idx_q, lock_idx_d;

   logic [BeatW-1:0] beats [NumInp];
   logic [IdxW-1:0]  cand;
   logic [IdxW-1:0]  idleSel;
   logic             anyValid;
   logic [IdxW-1:0]  sel;
   logic             haveBeat;
   logic             hs;
   logic             selLast;

   // Explicit wrap keeps the pointer inside 0..NumInp-1 for non-power-of-2 NumInp.
   function automatic logic [IdxW-1:0] incWrap(input logic [IdxW-1:0] v);
      return (v == LastIdx) ? '0 : v + IdxW'(1);
   endfunction

   for (genvar k = 0; k < NumInp; k++) begin : gen_beats
      assign beats[k] = data_i[k*BeatW +: BeatW];
   end

   always_comb begin
      idleSel  = rr_q;
      anyValid = 1'b0;
      cand     = rr_q;
      for (int unsigned i = 0; i < NumInp; i++) begin
         if (!anyValid && valid_i[cand]) begin
            idleSel  = cand;
            anyValid = 1'b1;
         end
         cand = incWrap(cand);
      end
   end

   // Outputs are forced quiet while reset is held and during a flush cycle.
   always_comb begin
      sel      = (state_q == StLocked) ? lock_idx_q : idleSel;
      haveBeat = (state_q == StLocked) | anyValid;
      valid_o  = valid_i[sel] & ~flush_i & rst_ni;
      data_o   = (haveBeat & rst_ni) ? beats[sel] : '0;
      idx_o    = sel;
      locked_o = (state_q == StLocked);
      ready_o  = '0;
      if (ready_i && !flush_i && rst_ni) begin
         ready_o[sel] = 1'b1;
      end
      selLast  = beats[sel][UserWidth];
      hs       = valid_o & ready_i;
   end

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      lock_idx_d = lock_idx_q;
      if (flush_i) begin
         state_d    = StIdle;
         rr_d       = '0;
         lock_idx_d = '0;
      end else if (hs && selLast) begin
         state_d = StIdle;
         rr_d    = incWrap(sel);
      end else if (valid_o && (state_q == StIdle)) begin
         // A stalled first beat must also lock so the presented beat stays stable.
         state_d    = StLocked;
         lock_idx_d = sel;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         rr_q       <= '0;
         lock_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         lock_idx_q <= lock_idx_d;
      end
   end

endmodule

// File: tb/tb_axi_r_chan_burst_arbiter.sv
// Scoreboard bench for axi_r_chan_burst_arbiter: directed scenarios, random traffic against
// a requester-level reference model, and a 3-input instance for the pointer wrap.
module tb_axi_r_chan_burst_arbiter;

   localparam int N  = 4;
   localparam int BW = 72;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic            flush_i;
   logic [N-1:0]    valid_i;
   logic [N-1:0]    ready_o;
   logic [N*BW-1:0] data_i;
   logic            valid_o;
   logic            ready_i;
   logic [BW-1:0]   data_o;
   logic [1:0]      idx_o;
   logic            locked_o;

   logic            flush3;
   logic [2:0]      valid3;
   logic [2:0]      ready3;
   logic [3*BW-1:0] data3;
   logic            valid3_o;
   logic            ready3_i;
   logic [BW-1:0]   data3_o;
   logic [1:0]      idx3_o;
   logic            locked3_o;

   always #5 clk = ~clk;

   axi_r_chan_burst_arbiter u_dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .idx_o(idx_o),
      .locked_o(locked_o)
   );

   axi_r_chan_burst_arbiter #(.NumInp(3)) u_dut3 (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush3), .valid_i(valid3), .ready_o(ready3),
      .data_i(data3), .valid_o(valid3_o), .ready_i(ready3_i), .data_o(data3_o), .idx_o(idx3_o),
      .locked_o(locked3_o)
   );

   int           checks = 0;
   int           errors = 0;

   // Requester-side state and arbiter reference model.
   bit           pres [N];
   int           beatsLeft [N];
   logic [BW-1:0] curBeat [N];
   int           mOwner = -1;
   int           mRr = 0;
   bit           readyIn, flushIn;

   bit           monEn = 1'b0;
   bit           expValid, expLocked;
   int           expIdx;
   logic [N-1:0] expReady;
   logic [BW-1:0] expData;

   logic [BW-1:0] expBeatQ [$];
   int           expIdxQ [$];
   int           hsLog [$];
   int           lockCycles = 0;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [BW-1:0] makeBeat(input int k, input bit last);
      return {4'(k), $urandom, $urandom, 2'($urandom), last, 1'($urandom)};
   endfunction

   task automatic driveInputs();
      for (int k = 0; k < N; k++) begin
         valid_i[k]            = pres[k];
         data_i[k*BW +: BW]    = curBeat[k];
      end
      ready_i = readyIn;
      flush_i = flushIn;
   endtask

   // Arbitration rules at requester level: who wins, what is presented, who owns the channel.
   task automatic modelEval();
      int  sel;
      bit  found;
      bit  vo;
      bit  last;
      found = 1'b0;
      sel   = mRr;
      if (mOwner >= 0) begin
         sel = mOwner;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!found && pres[(mRr + i) % N]) begin
               sel   = (mRr + i) % N;
               found = 1'b1;
            end
         end
      end
      vo        = pres[sel] && !flushIn;
      last      = curBeat[sel][1];
      expValid  = vo;
      expIdx    = sel;
      expLocked = (mOwner >= 0);
      expReady  = (readyIn && !flushIn) ? N'(1 << sel) : '0;
      expData   = ((mOwner >= 0) || found) ? curBeat[sel] : '0;
      if (flushIn) begin
         mOwner = -1;
         mRr    = 0;
      end else if (vo && readyIn) begin
         expBeatQ.push_back(curBeat[sel]);
         expIdxQ.push_back(sel);
         pres[sel] = 1'b0;
         beatsLeft[sel]--;
         if (last) begin
            mOwner = -1;
            mRr    = (sel + 1) % N;
         end else begin
            mOwner = sel;
         end
      end else if (vo) begin
         mOwner = sel;
      end
   endtask

   task automatic applyStimulus(input bit rnd, input logic [3:0] startMask, input logic [3:0] holdMask,
                                input logic [15:0] lens, input bit rdy, input bit fl, input bit rel);
      bit goOn;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         if (!pres[k]) begin
            goOn = 1'b0;
            if (rnd) begin
               if (beatsLeft[k] > 0) goOn = ($urandom_range(0, 9) < 8);
               else if ($urandom_range(0, 1) == 1) begin
                  beatsLeft[k] = int'($urandom_range(1, 4));
                  goOn = 1'b1;
               end
            end else begin
               if (beatsLeft[k] > 0) goOn = !holdMask[k];
               else if (startMask[k]) begin
                  beatsLeft[k] = int'(lens[k*4 +: 4]);
                  goOn = 1'b1;
               end
            end
            if (goOn) begin
               pres[k]    = 1'b1;
               curBeat[k] = makeBeat(k, beatsLeft[k] == 1);
            end
         end
      end
      readyIn = rnd ? ($urandom_range(0, 3) != 0) : rdy;
      flushIn = rnd ? ($urandom_range(0, 49) == 0) : fl;
      driveInputs();
      if (rel) rst_ni = 1'b1;
      monEn = 1'b1;
      #1 modelEval();
   endtask

   task automatic drainAndFlush();
      repeat (20) applyStimulus(1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b1, 1'b1, 1'b0);
   endtask

   // Monitor: per-cycle output checks and scoreboard pop on every DUT handshake.
   always @(negedge clk) begin
      #2;
      if (monEn) begin
         checkOutput("valid_o", valid_o, expValid);
         checkOutput("ready_o", ready_o, expReady);
         checkOutput("locked_o", locked_o, expLocked);
         checkOutput("data_o", data_o, expData);
         if (expValid) checkOutput("idx_o", idx_o, expIdx);
         if (locked_o) lockCycles++;
         if (valid_o && ready_i) begin
            hsLog.push_back(int'(idx_o));
            if (expBeatQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL sb_unexpected: handshake idx %0d, expected no handshake", idx_o);
            end else begin
               checkOutput("sb_idx", idx_o, expIdxQ.pop_front());
               checkOutput("sb_beat", data_o, expBeatQ.pop_front());
            end
         end
      end
   end

   initial begin
      int expSeq [5];
      logic [BW-1:0] stallData;
      rst_ni   = 1'b0;
      flush3   = 1'b0;
      valid3   = '0;
      data3    = '0;
      ready3_i = 1'b0;
      for (int k = 0; k < N; k++) begin
         pres[k]      = 1'b1;
         beatsLeft[k] = 1;
         curBeat[k]   = makeBeat(k, 1'b1);
      end
      readyIn = 1'b1;
      flushIn = 1'b0;
      driveInputs();

      // Reset held with every requester valid.
      repeat (3) @(negedge clk);
      #2;
      checkOutput("rst_valid_o", valid_o, 1'b0);
      checkOutput("rst_ready_o", ready_o, 4'b0000);
      checkOutput("rst_locked_o", locked_o, 1'b0);
      checkOutput("rst_data_o", data_o, '0);

      // Release, then single-beat round robin with all requesters valid.
      applyStimulus(1'b0, 4'hF, 4'h0, 16'h1111, 1'b1, 1'b0, 1'b1);
      #1 checkOutput("rel_idx_o", idx_o, 0);
      repeat (4) applyStimulus(1'b0, 4'hF, 4'h0, 16'h1111, 1'b1, 1'b0, 1'b0);
      #3;
      expSeq = '{0, 1, 2, 3, 0};
      checkOutput("rr_count", hsLog.size(), 5);
      for (int i = 0; i < 5 && i < hsLog.size(); i++) checkOutput("rr_order", hsLog[i], expSeq[i]);

      // Burst lock: req1 sends 4 beats while req0 and req2 keep requesting.
      drainAndFlush();
      applyStimulus(1'b0, 4'b0001, 4'h0, 16'h0001, 1'b1, 1'b0, 1'b0);
      #3;
      hsLog.delete();
      lockCycles = 0;
      repeat (5) applyStimulus(1'b0, 4'b0111, 4'h0, 16'h0141, 1'b1, 1'b0, 1'b0);
      #3;
      expSeq = '{1, 1, 1, 1, 2};
      checkOutput("lock_count", hsLog.size(), 5);
      for (int i = 0; i < 5 && i < hsLog.size(); i++) checkOutput("lock_order", hsLog[i], expSeq[i]);
      checkOutput("lock_cycles", lockCycles, 3);

      // Stall stability: req3 held with ready_i low, then req0 joins.
      drainAndFlush();
      applyStimulus(1'b0, 4'b1000, 4'h0, 16'h1000, 1'b0, 1'b0, 1'b0);
      stallData = curBeat[3];
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b0, (c == 4) ? 4'b1001 : 4'b1000, 4'h0, 16'h1001, 1'b0, 1'b0, 1'b0);
         #1;
         checkOutput("stall_idx", idx_o, 3);
         checkOutput("stall_data", data_o, stallData);
         checkOutput("stall_lock", locked_o, 1'b1);
         checkOutput("stall_ready", ready_o, 4'b0000);
      end
      applyStimulus(1'b0, 4'b1001, 4'h0, 16'h1001, 1'b1, 1'b0, 1'b0);

      // Gap mid-burst on req2, then flush and fresh search from 0.
      drainAndFlush();
      applyStimulus(1'b0, 4'b0100, 4'h0, 16'h0400, 1'b1, 1'b0, 1'b0);
      repeat (2) begin
         applyStimulus(1'b0, 4'b0010, 4'b0100, 16'h0010, 1'b1, 1'b0, 1'b0);
         #1;
         checkOutput("gap_valid_o", valid_o, 1'b0);
         checkOutput("gap_ready1", ready_o[1], 1'b0);
      end
      applyStimulus(1'b0, 4'b0010, 4'b0100, 16'h0010, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0110, 4'h0, 16'h0410, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("flush_locked", locked_o, 1'b0);
      checkOutput("flush_idx", idx_o, 1);

      // Random traffic with occasional flushes and one asynchronous reset mid-run.
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) begin
            applyStimulus(1'b1, 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            #2;
            monEn  = 1'b0;
            rst_ni = 1'b0;
            #1;
            checkOutput("arst_locked", locked_o, 1'b0);
            checkOutput("arst_valid", valid_o, 1'b0);
            checkOutput("arst_ready", ready_o, 4'b0000);
            mOwner = -1;
            mRr    = 0;
            applyStimulus(1'b1, 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b1);
         end else begin
            applyStimulus(1'b1, 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0);
         end
      end
      #3;
      monEn = 1'b0;
      checkOutput("sb_empty", expBeatQ.size(), 0);

      // Three-input instance: pointer must wrap from 2 back to 0.
      for (int k = 0; k < 3; k++) data3[k*BW +: BW] = makeBeat(k, 1'b1);
      expSeq = '{0, 1, 2, 0, 1};
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         valid3   = 3'b111;
         ready3_i = 1'b1;
         #2;
         checkOutput("n3_idx", idx3_o, expSeq[c]);
         checkOutput("n3_valid", valid3_o, 1'b1);
         checkOutput("n3_data", data3_o, data3[expSeq[c]*BW +: BW]);
         checkOutput("n3_locked", locked3_o, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
